apb_initiator: RTL and testbench
================================

APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, max ACCESS-phase cycles awaiting pready; 0 disables timeout.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req_i  input  1  request from local initiator.
REQ-008 addr_i  input  APB_ADDR_WIDTH  request address.
REQ-009 we_i  input  1  1 = write, 0 = read.
REQ-010 wdata_i  input  APB_DATA_WIDTH  write data.
REQ-011 gnt_o  output  1  request accepted this cycle.
REQ-012 rvalid_o  output  1  one-cycle completion pulse.
REQ-013 rdata_o  output  APB_DATA_WIDTH  read data, valid with rvalid_o.
REQ-014 err_o  output  1  slave error or timeout, valid with rvalid_o.
REQ-015 paddr_o, pwdata_o (input-width), pwrite_o, psel_o, penable_o  outputs  APB master-side request signals.
REQ-016 prdata_i  input  APB_DATA_WIDTH; pready_i, pslverr_i  input  1  APB slave response.

Function
REQ-017 FSM states IDLE, SETUP, ACCESS; single outstanding transfer.
REQ-018 gnt_o = req_i AND state==IDLE (combinational); acceptance = req_i & gnt_o.
REQ-019 On acceptance: capture addr_i/we_i/wdata_i into paddr_o/pwrite_o/pwdata_o; IDLE->SETUP.
REQ-020 SETUP: psel_o=1, penable_o=0 for exactly one cycle; SETUP->ACCESS.
REQ-021 ACCESS: psel_o=1, penable_o=1; paddr_o/pwrite_o/pwdata_o stable throughout SETUP and ACCESS.
REQ-022 ACCESS with pready_i=1: ACCESS->IDLE; next cycle rvalid_o=1, err_o=pslverr_i, rdata_o=prdata_i for reads, 0 for writes.
REQ-023 Latency: accept at cycle T, SETUP T+1, ACCESS T+2, earliest rvalid_o T+3; new acceptance allowed in the rvalid_o cycle (3-cycle minimum per transfer).
REQ-024 Wait counter clears on entering ACCESS, increments each ACCESS cycle with pready_i=0, saturates.
REQ-025 Timeout (TIMEOUT_CYCLES>0): ACCESS cycle with pready_i=0 and counter==TIMEOUT_CYCLES-1 -> IDLE, psel_o/penable_o drop next cycle, rvalid_o=1, err_o=1, rdata_o=0.
REQ-026 pready_i=1 in the timeout cycle SHALL complete normally (pready wins).
REQ-027 psel_o/penable_o=0 in IDLE; paddr_o/pwrite_o/pwdata_o hold last value in IDLE.
REQ-028 rvalid_o SHALL never assert without a preceding acceptance; exactly one rvalid_o per acceptance.
REQ-029 pready_i/pslverr_i/prdata_i ignored outside ACCESS.

Reset
REQ-030 rst=1 at an edge: state=IDLE, psel_o/penable_o/pwrite_o/rvalid_o/err_o=0, paddr_o/pwdata_o/rdata_o=0, counter=0.
REQ-031 rst mid-transfer aborts silently: APB signals deasserted next cycle, no rvalid_o.
REQ-032 gnt_o=0 while rst=1.

Structure
REQ-033 Package apb_initiator_pkg SHALL hold the FSM state enum and default TIMEOUT_CYCLES constant.
REQ-034 Wait counter SHALL be sub-module apb_timeout_cnt (clear, enable, parameterised width, expired flag).
REQ-035 Top SHALL be instantiable behind an APB_BUS Master modport via the team's assign macros.

Verification
REQ-036 Read, pready_i=1 at first ACCESS, prdata_i=32'hDEAD_BEEF, addr 32'h1A10_1000 -> psel T+1, penable T+2, rvalid_o T+3, rdata_o=32'hDEAD_BEEF, err_o=0.
REQ-037 Write 32'h0000_00A5 to 32'h1A10_3004, pready after 4 wait cycles -> pwdata/paddr stable 6 cycles, rvalid_o once, rdata_o=0.
REQ-038 pready_i never asserted, TIMEOUT_CYCLES=8 -> 8 ACCESS cycles, then rvalid_o=1, err_o=1, rdata_o=0.
REQ-039 pslverr_i=1 with pready_i=1 -> err_o=1 with rvalid_o; back-to-back req_i held high -> gnt_o in rvalid_o cycle, transfers every 3 cycles.
REQ-040 rst asserted during ACCESS -> psel_o=0, penable_o=0 next cycle, no rvalid_o; pready_i=1 in timeout cycle -> err_o=pslverr_i, not timeout.

Source files
------------

// File: rtl/apb_initiator_pkg.sv
// Shared types and constants for the APB initiator and its wait counter.
package apb_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Counter width able to hold values up to limit (at least one bit).
  function automatic int cnt_width(input int limit);
    if (limit < 2) return 1;
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-phase wait counter with a timeout flag.
module apb_timeout_cnt #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WIDTH-1:0] count_reg;

  // Clear has priority; counting stops at all-ones so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // A limit of zero means the timeout is disabled.
  generate
    if (LIMIT > 0) begin : g_limit
      assign expired = (count_reg == WIDTH'(LIMIT - 1));
    end else begin : g_nolimit
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/apb_initiator.sv
// APB master: turns a req/gnt local request into one SETUP+ACCESS transfer
// and reports completion with a single rvalid_o pulse.
module apb_initiator
  import apb_initiator_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

  apb_state_e                state_reg;
  logic [APB_ADDR_WIDTH-1:0] paddr_reg;
  logic [APB_DATA_WIDTH-1:0] pwdata_reg;
  logic                      pwrite_reg;
  logic                      psel_reg;
  logic                      penable_reg;
  logic                      rvalid_reg;
  logic                      err_reg;
  logic [APB_DATA_WIDTH-1:0] rdata_reg;
  logic                      wait_expired;
  logic                      timeout_hit;

  // Counter is zeroed during SETUP so the first ACCESS cycle sees 0.
  apb_timeout_cnt #(
    .WIDTH (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_reg == SETUP),
    .enable  ((state_reg == ACCESS) && !pready_i),
    .expired (wait_expired)
  );

  // pready_i wins over the timeout when both happen in the same cycle.
  assign timeout_hit = (state_reg == ACCESS) && !pready_i && wait_expired;

  assign gnt_o = req_i && (state_reg == IDLE) && !rst;

  // Transfer sequencer; all APB and completion outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
      pwrite_reg  <= 1'b0;
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      err_reg     <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_i) begin
            paddr_reg   <= addr_i;
            pwdata_reg  <= wdata_i;
            pwrite_reg  <= we_i;
            psel_reg    <= 1'b1;
            penable_reg <= 1'b0;
            state_reg   <= SETUP;
          end
        end
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            psel_reg    <= 1'b0;
            penable_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            err_reg     <= pslverr_i;
            rdata_reg   <= pwrite_reg ? '0 : prdata_i;
            state_reg   <= IDLE;
          end else if (timeout_hit) begin
            psel_reg    <= 1'b0;
            penable_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            err_reg     <= 1'b1;
            rdata_reg   <= '0;
            state_reg   <= IDLE;
          end
        end
        default: begin
          psel_reg    <= 1'b0;
          penable_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign paddr_o   = paddr_reg;
  assign pwdata_o  = pwdata_reg;
  assign pwrite_o  = pwrite_reg;
  assign psel_o    = psel_reg;
  assign penable_o = penable_reg;
  assign rvalid_o  = rvalid_reg;
  assign err_o     = err_reg;
  assign rdata_o   = rdata_reg;

endmodule

// File: tb/tb_apb_initiator.sv
// Scoreboard bench: a driver issues requests and queues the expected
// completion, a slave model answers with planned wait counts, and a
// monitor compares every cycle against the queued expectations.
module tb_apb_initiator;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o, rvalid_o, err_o, pwrite_o, psel_o, penable_o;
  logic [31:0] rdata_o, paddr_o, pwdata_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;

  apb_initiator #(
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .wdata_i   (wdata_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .pwrite_o  (pwrite_o),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          we;
    bit          err;
    int          acc;
    int          exp_cyc;
  } exp_t;

  typedef struct {
    int          w;
    logic [31:0] pd;
    bit          se;
  } plan_t;

  exp_t  sb[$];
  plan_t plans[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: pready after the planned number of ACCESS wait cycles,
  // random noise on the response lines whenever not in ACCESS.
  int          s_cnt = 0;
  int          s_w = 1000;
  logic [31:0] s_pd = '0;
  bit          s_se = 1'b0;
  always @(posedge clk) begin
    #2;
    if (psel_o && penable_o) begin
      if (s_cnt == s_w) begin
        pready_i  = 1'b1;
        prdata_i  = s_pd;
        pslverr_i = s_se;
      end else begin
        pready_i  = 1'b0;
        prdata_i  = $urandom;
        pslverr_i = 1'($urandom_range(0, 1));
      end
      s_cnt++;
    end else begin
      if (psel_o && plans.size() > 0) begin
        s_w  = plans[0].w;
        s_pd = plans[0].pd;
        s_se = plans[0].se;
        void'(plans.pop_front());
        s_cnt = 0;
      end
      pready_i  = 1'($urandom_range(0, 1));
      prdata_i  = $urandom;
      pslverr_i = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: checks grant, APB phase signals, held request fields and completions.
  bit exp_idle, exp_gnt, exp_psel, exp_pen;
  always @(negedge clk) begin
    if (rst) begin
      total++;
      if (gnt_o !== 1'b0) begin
        bad++;
        $display("FAIL gnt_in_reset: got %b want 0", gnt_o);
      end
    end else begin
      exp_idle = (sb.size() == 0) || (sb[0].exp_cyc == cyc);
      exp_gnt  = req_i && exp_idle;
      exp_psel = (sb.size() > 0) && (cyc >= sb[0].acc + 1) && (cyc < sb[0].exp_cyc);
      exp_pen  = exp_psel && (cyc >= sb[0].acc + 2);
      total++;
      if (gnt_o !== exp_gnt) begin
        bad++;
        $display("FAIL gnt cyc=%0d: got %b want %b", cyc, gnt_o, exp_gnt);
      end
      total++;
      if (psel_o !== exp_psel || penable_o !== exp_pen) begin
        bad++;
        $display("FAIL phase cyc=%0d: got psel=%b penable=%b want psel=%b penable=%b",
                 cyc, psel_o, penable_o, exp_psel, exp_pen);
      end
      if (exp_psel) begin
        total++;
        if (paddr_o !== sb[0].addr || pwdata_o !== sb[0].wdata || pwrite_o !== sb[0].we) begin
          bad++;
          $display("FAIL req_hold cyc=%0d: got addr=%h wdata=%h we=%b want addr=%h wdata=%h we=%b",
                   cyc, paddr_o, pwdata_o, pwrite_o, sb[0].addr, sb[0].wdata, sb[0].we);
        end
      end
      if (rvalid_o) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL spurious_rvalid cyc=%0d: got rvalid=1 want 0", cyc);
        end else begin
          if (cyc != sb[0].exp_cyc || rdata_o !== sb[0].rdata || err_o !== sb[0].err) begin
            bad++;
            $display("FAIL completion: got cyc=%0d rdata=%h err=%b want cyc=%0d rdata=%h err=%b",
                     cyc, rdata_o, err_o, sb[0].exp_cyc, sb[0].rdata, sb[0].err);
          end else begin
            $display("txn acc=%0d done=%0d addr=%h we=%b rdata=%h err=%b",
                     sb[0].acc, cyc, sb[0].addr, sb[0].we, rdata_o, err_o);
          end
          void'(sb.pop_front());
        end
      end else if (sb.size() > 0 && cyc >= sb[0].exp_cyc) begin
        total++;
        bad++;
        $display("FAIL missing_rvalid cyc=%0d: got rvalid=0 want 1", cyc);
        void'(sb.pop_front());
      end
    end
  end

  // Drive one request, wait (bounded) for grant, queue plan and expectation.
  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input int w, input logic [31:0] pd, input bit se, output int acc);
    int   budget;
    exp_t e;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = a;
    wdata_i = wd;
    budget  = 0;
    acc     = -1;
    @(negedge clk);
    while (!gnt_o) begin
      budget++;
      if (budget > 100) begin
        total++;
        bad++;
        $display("FAIL grant_timeout: got gnt=0 for %0d cycles want 1", budget);
        req_i = 1'b0;
        return;
      end
      @(negedge clk);
    end
    acc = cyc;
    @(posedge clk);
    #1;
    req_i     = 1'b0;
    e.addr    = a;
    e.wdata   = wd;
    e.we      = we;
    e.acc     = acc;
    if (w >= TO) begin
      e.rdata   = '0;
      e.err     = 1'b1;
      e.exp_cyc = acc + 3 + (TO - 1);
    end else begin
      e.rdata   = we ? 32'h0 : pd;
      e.err     = se;
      e.exp_cyc = acc + 3 + w;
    end
    sb.push_back(e);
    plans.push_back('{w: w, pd: pd, se: se});
  endtask

  task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    int acc0, acc1, budget;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_val("rst_psel",    {31'b0, psel_o},    32'h0);
    expect_val("rst_penable", {31'b0, penable_o}, 32'h0);
    expect_val("rst_pwrite",  {31'b0, pwrite_o},  32'h0);
    expect_val("rst_rvalid",  {31'b0, rvalid_o},  32'h0);
    expect_val("rst_err",     {31'b0, err_o},     32'h0);
    expect_val("rst_paddr",   paddr_o,            32'h0);
    expect_val("rst_pwdata",  pwdata_o,           32'h0);
    expect_val("rst_rdata",   rdata_o,            32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases.
    issue(1'b0, 32'h1A10_1000, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, acc0);
    issue(1'b1, 32'h1A10_3004, 32'h0000_00A5, 4, 32'h1234_5678, 1'b0, acc0);
    issue(1'b0, 32'h1A10_2000, 32'h0, 1000, 32'h5555_AAAA, 1'b0, acc0);
    issue(1'b0, 32'h1A10_2004, 32'h0, 2, 32'h0BAD_F00D, 1'b1, acc0);
    issue(1'b0, 32'h1A10_2008, 32'h0, TO - 1, 32'hCAFE_0001, 1'b0, acc0);
    issue(1'b1, 32'h1A10_200C, 32'h7777_7777, TO - 1, 32'hCAFE_0002, 1'b1, acc0);

    // Back-to-back with req held: next grant lands in the rvalid cycle.
    issue(1'b0, 32'h0000_0100, 32'h0, 0, 32'h0000_1111, 1'b0, acc0);
    issue(1'b1, 32'h0000_0104, 32'hABCD_0000, 0, 32'h0000_2222, 1'b0, acc1);
    expect_val("b2b_spacing", acc1 - acc0, 32'd3);
    issue(1'b0, 32'h0000_0108, 32'h0, 0, 32'h0000_3333, 1'b1, acc0);
    expect_val("b2b_spacing2", acc0 - acc1, 32'd3);

    // Reset during ACCESS aborts silently.
    issue(1'b0, 32'h0000_0200, 32'h0, 1000, 32'h0, 1'b0, acc0);
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b1;
    req_i = 1'b1;
    sb.delete();
    plans.delete();
    s_w = 1000;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    req_i = 1'b0;
    @(negedge clk);
    expect_val("abort_psel",    {31'b0, psel_o},    32'h0);
    expect_val("abort_penable", {31'b0, penable_o}, 32'h0);
    repeat (12) @(posedge clk);
    #1;

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int gap;
      issue(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 10),
            $urandom, 1'($urandom_range(0, 1)), acc0);
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      #1;
    end

    budget = 0;
    while (sb.size() > 0 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
